// File: rtl/serial_addsub.sv
// Digit-serial ripple adder/subtractor: DIGIT bits per clock through a
// full-adder chain, with a registered inter-digit carry and valid/ready handshakes.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0] digit_sum;
  logic             chain_cout;
  logic             carry_into_top;
  logic [WIDTH-1:0] next_res;

  // Ripple chain over the low DIGIT bits; carry_into_top is the carry entering
  // the top cell, which on the last digit is the carry into the result MSB.
  always_comb begin
    logic c;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    digit_sum      = '0;
    carry_into_top = 1'b0;
    c              = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_sum[i]   = a_sr[i] ^ b_sr[i] ^ c;
      carry_into_top = c;
      c              = (a_sr[i] & b_sr[i]) | ((a_sr[i] ^ b_sr[i]) & c);
    end
    chain_cout = c;
  end

  // New digit enters at the MSB end so the word is aligned after N shifts.
  assign next_res = (res_sr >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      c_out    <= 1'b0;
      ovf_out  <= 1'b0;
      zero_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr    <= a_in;
            b_sr    <= b_in ^ {WIDTH{sub_in}};
            carry_q <= sub_in;
            cnt     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr    <= a_sr >> DIGIT;
          b_sr    <= b_sr >> DIGIT;
          res_sr  <= next_res;
          carry_q <= chain_cout;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_DIGIT) begin
            sum_out  <= next_res;
            c_out    <= chain_cout;
            ovf_out  <= chain_cout ^ carry_into_top;
            zero_out <= (next_res == '0);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: four parameter sets driven in turn,
// results compared against an arithmetic reference model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] a, b;
  logic        sub;
  logic        out_ready;

  logic [3:0]  rdy_o, vld_o, c_o, ovf_o, zero_o;
  logic [15:0] sum0;
  logic [7:0]  sum1, sum2;
  logic [31:0] sum3;

  int passed = 0;
  int total  = 0;

  localparam int W_OF [4] = '{16, 8, 8, 32};
  localparam int N_OF [4] = '{4, 8, 1, 4};

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_w16_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy_o[0]),
    .a_in(a[15:0]), .b_in(b[15:0]), .sub_in(sub), .out_valid(vld_o[0]),
    .out_ready(out_ready), .sum_out(sum0), .c_out(c_o[0]), .ovf_out(ovf_o[0]),
    .zero_out(zero_o[0]));

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy_o[1]),
    .a_in(a[7:0]), .b_in(b[7:0]), .sub_in(sub), .out_valid(vld_o[1]),
    .out_ready(out_ready), .sum_out(sum1), .c_out(c_o[1]), .ovf_out(ovf_o[1]),
    .zero_out(zero_o[1]));

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_w8_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy_o[2]),
    .a_in(a[7:0]), .b_in(b[7:0]), .sub_in(sub), .out_valid(vld_o[2]),
    .out_ready(out_ready), .sum_out(sum2), .c_out(c_o[2]), .ovf_out(ovf_o[2]),
    .zero_out(zero_o[2]));

  serial_addsub #(.WIDTH(32), .DIGIT(8)) u_w32_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(rdy_o[3]),
    .a_in(a), .b_in(b), .sub_in(sub), .out_valid(vld_o[3]),
    .out_ready(out_ready), .sum_out(sum3), .c_out(c_o[3]), .ovf_out(ovf_o[3]),
    .zero_out(zero_o[3]));

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return {16'd0, sum0};
      1:       return {24'd0, sum1};
      2:       return {24'd0, sum2};
      default: return sum3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: true signed/unsigned arithmetic, then reduce to WIDTH bits.
  task automatic model(input int w, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic s, output logic [31:0] es, output logic ec,
                       output logic eo, output logic ez);
    longint unsigned m  = (64'd1 << w) - 64'd1;
    longint unsigned ua = {32'd0, a_v} & m;
    longint unsigned ub = {32'd0, b_v} & m;
    longint unsigned r;
    longint sa, sb, st, lim;
    lim = longint'(64'd1 << (w - 1));
    sa  = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
    sb  = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
    r   = s ? (ua - ub) : (ua + ub);
    st  = s ? (sa - sb) : (sa + sb);
    es  = 32'(r & m);
    ec  = s ? (ua >= ub) : (((ua + ub) >> w) != 0);
    eo  = (st < -lim) || (st > lim - 1);
    ez  = ((r & m) == 0);
  endtask

  // One full transaction on DUT k; poke pulses in_valid while the result is held.
  task automatic run_op(input int k, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic s, input int hold, input bit poke, input string tag);
    logic [31:0] es;
    logic ec, eo, ez;
    int guard, lat;
    model(W_OF[k], a_v, b_v, s, es, ec, eo, ez);
    guard = 0;
    while (!rdy_o[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_ready"}, 32'(rdy_o[k]), 32'd1);
    a = a_v; b = b_v; sub = s; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    lat = 0;
    while (!vld_o[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(N_OF[k]));
    check({tag, " sum"},  sum_of(k),      es);
    check({tag, " c"},    32'(c_o[k]),    32'(ec));
    check({tag, " ovf"},  32'(ovf_o[k]),  32'(eo));
    check({tag, " zero"}, 32'(zero_o[k]), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = (poke && i == 4);
      @(posedge clk); #1;
      check({tag, " held sum"},       sum_of(k),     es);
      check({tag, " held out_valid"}, 32'(vld_o[k]), 32'd1);
      check({tag, " held in_ready"},  32'(rdy_o[k]), 32'd0);
    end
    in_valid[k] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after xfer"}, 32'(vld_o[k]), 32'd0);
    check({tag, " in_ready after xfer"},  32'(rdy_o[k]), 32'd1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      check({tag, " poke not captured"}, 32'(rdy_o[k]), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] m;
    rst = 1'b1; in_valid = '0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset%0d in_ready", k),  32'(rdy_o[k]),  32'd1);
      check($sformatf("reset%0d out_valid", k), 32'(vld_o[k]),  32'd0);
      check($sformatf("reset%0d sum", k),       sum_of(k),      32'd0);
      check($sformatf("reset%0d flags", k),
            {29'd0, c_o[k], ovf_o[k], zero_o[k]}, 32'd0);
    end

    run_op(0, 32'h1234, 32'h4321, 1'b0, 0, 1'b0, "add 1234+4321");
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 0, 1'b0, "add 7fff+1");
    run_op(0, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, "add ffff+1");
    run_op(0, 32'h0005, 32'h0007, 1'b1, 0, 1'b0, "sub 5-7");
    run_op(0, 32'h8000, 32'h0001, 1'b1, 0, 1'b0, "sub 8000-1");
    run_op(0, 32'h1234, 32'h1234, 1'b1, 0, 1'b0, "sub 1234-1234");
    run_op(0, 32'h1234, 32'h4321, 1'b0, 10, 1'b1, "backpressure");

    // Reset on the second RUN cycle discards the operation in flight.
    a = 32'h1111; b = 32'h2222; sub = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun rst in_ready",  32'(rdy_o[0]), 32'd1);
    check("midrun rst out_valid", 32'(vld_o[0]), 32'd0);
    check("midrun rst sum",       sum_of(0),     32'd0);
    check("midrun rst flags", {29'd0, c_o[0], ovf_o[0], zero_o[0]}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midrun rst no result", 32'(vld_o[0]), 32'd0);
    run_op(0, 32'h0003, 32'h0004, 1'b0, 0, 1'b0, "after rst 3+4");

    run_op(1, 32'h7F, 32'h01, 1'b0, 0, 1'b0, "w8d1 7f+1");
    run_op(2, 32'h7F, 32'h01, 1'b0, 0, 1'b0, "w8d8 7f+1");
    run_op(3, 32'h7FFFFFFF, 32'h1, 1'b0, 0, 1'b0, "w32 7fffffff+1");
    run_op(3, 32'h0, 32'h1, 1'b1, 0, 1'b0, "w32 0-1");

    for (int k = 0; k < 4; k++) begin
      m = (W_OF[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W_OF[k]) - 32'd1);
      for (int i = 0; i < 20; i++) begin
        run_op(k, $urandom & m, $urandom & m, 1'($urandom), $urandom_range(0, 3), 1'b0,
               $sformatf("rand cfg%0d #%0d", k, i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
